// File: rtl/fifo_rd_stream_if.sv
// Purpose: bundles the FIFO read port and the downstream valid/ready stream.
// Latency: none (wiring only).
// Backpressure: out_ready from the sink throttles r_valid toward the FIFO.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic              empty;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // The stream engine drives the read strobe and the output stream.
  modport master (
    input  empty,
    input  r_data,
    input  out_ready,
    output r_valid,
    output out_valid,
    output out_data
  );

  // The FIFO side and the sink together form the opposite end.
  modport slave (
    output empty,
    output r_data,
    output out_ready,
    input  r_valid,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Purpose: reads words from the async FIFO read port into a 2-entry buffer and streams them out.
// Latency: 2 cycles from an accepted read to out_valid; one word per cycle sustained.
// Backpressure: r_valid only issues when the buffer plus the in-flight word leaves room after this cycle's pop.
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk_rd,
  input  logic               rst_n,
  input  logic               flush,
  fifo_rd_stream_if.master   bus,
  output logic [1:0]         occ,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic [1:0]        occ_q;
  logic              infl_q;
  logic              head_q;
  logic              tail_q;
  logic [DATA_W-1:0] mem_q [2];
  logic [CNT_W-1:0]  cnt_q;

  logic              pop;
  logic              req;
  logic              acc;
  logic [2:0]        level;

  // Occupancy after this edge; pop needs out_valid, so it never underflows.
  always_comb begin
    pop   = (occ_q != 2'd0) && bus.out_ready;
    level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    req   = rst_n && !bus.empty && !flush && (level < 3'd2);
    acc   = req && !bus.empty;
  end

  assign bus.r_valid   = req;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = mem_q[head_q];
  assign occ           = occ_q;
  assign beat_cnt      = cnt_q;

  // Buffer bookkeeping: flush drops both the held words and the returning one.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else if (flush) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      occ_q  <= level[1:0];
      infl_q <= acc;
      if (pop)    head_q <= ~head_q;
      if (infl_q) tail_q <= ~tail_q;
    end
  end

  // Capture the word returning from last cycle's accepted read.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (infl_q && !flush) begin
      mem_q[tail_q] <= bus.r_data;
    end
  end

  // Delivered-beat counter; a pop during flush still counts as delivered.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // The request rule guarantees the buffer never has to hold a third word.
  overflow_chk: assert property (@(posedge clk_rd) disable iff (!rst_n) (level <= 3'd2));

  // The strobe is never raised toward an empty FIFO.
  no_empty_read_chk: assert property (@(posedge clk_rd) disable iff (!rst_n) !(bus.r_valid && bus.empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Purpose: randomized and directed bench for fifo_rd_stream against a sequence-level model.
// Latency: model expects words visible 2 cycles after the read is accepted.
// Backpressure: out_ready is toggled directly and randomly to exercise stalls.
module tb_fifo_rd_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1024;

  logic             clk_rd;
  logic             rst_n;
  logic             flush;
  logic [1:0]       occ;
  logic [CNT_W-1:0] beat_cnt;

  fifo_rd_stream_if #(.DATA_W(DATA_W)) bus ();

  fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_rd   (clk_rd),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occ      (occ),
    .beat_cnt (beat_cnt)
  );

  // FIFO contents and pointers (word i lives at mem[i % DEPTH]).
  logic [DATA_W-1:0] mem [DEPTH];
  int wr_ptr;
  int rd_ptr;

  // Sequence model: reads accepted, words landed in the buffer, next word due out.
  int fetched;
  int landed;
  int next_idx;
  int exp_beats;

  int n_tests;
  int n_fail;

  initial clk_rd = 1'b0;
  always #5 clk_rd = ~clk_rd;

  assign bus.empty = (wr_ptr == rd_ptr);

  // FIFO read port: registered data one cycle after an accepted read, noise otherwise.
  always @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= 0;
      bus.r_data <= '0;
    end else if (bus.r_valid && !bus.empty) begin
      bus.r_data <= mem[rd_ptr % DEPTH];
      rd_ptr     <= rd_ptr + 1;
    end else begin
      bus.r_data <= DATA_W'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    mem[wr_ptr % DEPTH] = d;
    wr_ptr++;
  endtask

  task automatic model_reset();
    fetched   = 0;
    landed    = 0;
    next_idx  = 0;
    exp_beats = 0;
    wr_ptr    = 0;
  endtask

  // One clock cycle: called at a falling edge with inputs set; checks just before the rising edge.
  task automatic tick();
    int   exp_occ;
    logic exp_ov;
    logic exp_pop;
    logic exp_rv;
    int   held;
    #4;
    exp_occ = landed - next_idx;
    exp_ov  = (exp_occ != 0);
    exp_pop = exp_ov && bus.out_ready;
    held    = (fetched - next_idx) - (exp_pop ? 1 : 0);
    exp_rv  = ((wr_ptr - fetched) > 0) && !flush && (held < 2);
    check("occ", 32'(occ), exp_occ);
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("r_valid", 32'(bus.r_valid), 32'(exp_rv));
    check("beat_cnt", 32'(beat_cnt), 32'(exp_beats[CNT_W-1:0]));
    if (exp_ov) check("out_data", 32'(bus.out_data), 32'(mem[next_idx % DEPTH]));
    if (exp_pop) begin
      next_idx++;
      exp_beats++;
    end
    landed = fetched;
    if (exp_rv) fetched++;
    if (flush) begin
      next_idx = fetched;
      landed   = fetched;
    end
    @(posedge clk_rd);
    @(negedge clk_rd);
  endtask

  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset values, and no strobe under reset even with data available.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    push(8'hA5);
    #1;
    check("rst_r_valid", 32'(bus.r_valid), 32'd0);
    @(negedge clk_rd);
    rst_n = 1'b1;

    // Single word.
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("single_beats", 32'(beat_cnt), 32'd1);

    // Streaming 16 words at full rate.
    for (int i = 0; i < 16; i++) push(DATA_W'(i));
    repeat (22) tick();
    check("stream_beats", 32'(beat_cnt), 32'd17);

    // Backpressure: only two reads issue, head word holds.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(DATA_W'(8'h50 + i));
    repeat (6) tick();
    check("bp_occ", 32'(occ), 32'd2);
    check("bp_head", 32'(bus.out_data), 32'h50);
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("bp_beats", 32'(beat_cnt), 32'd22);

    // Flush with one word held and one in flight.
    bus.out_ready = 1'b0;
    push(8'h61);
    repeat (2) tick();
    push(8'h62);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_occ", 32'(occ), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    push(8'h63);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("flush_beats", 32'(beat_cnt), 32'd23);

    // Random traffic, stalls and flushes.
    for (int c = 0; c < 2000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      if (($urandom_range(0, 1) == 1) && ((wr_ptr - next_idx) < 500)) push(DATA_W'($urandom));
      tick();
    end
    flush = 1'b0;

    // Counter wrap at 2^CNT_W beats.
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_beats < 65536 && guard < 70000) begin
      if ((wr_ptr - fetched) < 4) push(DATA_W'($urandom));
      tick();
      guard++;
    end
    check("wrap_cnt", 32'(beat_cnt), 32'd0);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wrap_flush_cnt", 32'(beat_cnt), 32'd0);

    // Asynchronous reset while the buffer is full.
    for (int i = 0; i < 5; i++) push(DATA_W'(8'h70 + i));
    repeat (5) tick();
    check("pre_rst_occ", 32'(occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_occ", 32'(occ), 32'd0);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_r_valid", 32'(bus.r_valid), 32'd0);
    check("arst_beat_cnt", 32'(beat_cnt), 32'd0);
    model_reset();
    @(negedge clk_rd);
    rst_n = 1'b1;
    push(8'h81);
    push(8'h82);
    push(8'h83);
    bus.out_ready = 1'b1;
    repeat (8) tick();
    check("post_rst_beats", 32'(beat_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
